// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall controller.
// Merges ID/EX hazard requests with a sequencer for multi-cycle EX operations.
// The sequencer supports counted ops with a fixed latency and done-terminated ops
// guarded by a watchdog.
// Optional feature macro: STALL_STATS_EN adds the stall_cycles counter output.
module pipe_stall_ctrl #(
    parameter int CNT_W      = 7,
    parameter int MAX_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             mc_done,
    input  logic             mc_flush,
    output logic [5:0]       stall,
    output logic             mc_busy,
    output logic             mc_finish,
    output logic             mc_timeout
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    // Stall patterns: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_TO_ID = 6'b000111;
    localparam logic [5:0] STALL_TO_EX = 6'b001111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_mode_q, done_mode_d;
    logic             timeout_q, timeout_d;

    // State, counter, mode and sticky watchdog flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            done_mode_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_mode_q <= done_mode_d;
            timeout_q   <= timeout_d;
        end
    end

    // Sequencer next state: flush always wins over completion and watchdog.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_mode_d = done_mode_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (mc_start && !mc_flush) begin
                    state_d     = RUN;
                    cnt_d       = mc_cycles;
                    done_mode_d = (mc_cycles == CNT_ZERO);
                end
            end
            RUN: begin
                if (mc_flush) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (!done_mode_q) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (mc_done) begin
                        state_d = FIN;
                    end else if (cnt_q == WD_LIMIT) begin
                        state_d   = FIN;
                        timeout_d = 1'b1;
                    end
                end
            end
            FIN: begin
                // mc_start here belongs to the instruction now leaving EX.
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode; reset forces every output inactive regardless of requests.
    always_comb begin
        stall      = STALL_NONE;
        mc_busy    = 1'b0;
        mc_finish  = 1'b0;
        mc_timeout = 1'b0;
        if (!rst) begin
            if ((state_q == RUN) || stallreq_from_ex) begin
                stall = STALL_TO_EX;
            end else if (stallreq_from_id) begin
                stall = STALL_TO_ID;
            end
            mc_busy    = (state_q == RUN);
            mc_finish  = (state_q == FIN) && !mc_flush;
            mc_timeout = timeout_q;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q;

    // Count cycles in which EX is held; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (stall[3]) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: per-cycle expected outputs are queued when
// the stimulus is driven and compared once the DUT outputs have settled.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallreq_from_id = 1'b0;
    logic             stallreq_from_ex = 1'b0;
    logic             mc_start = 1'b0;
    logic [CNT_W-1:0] mc_cycles = '0;
    logic             mc_done = 1'b0;
    logic             mc_flush = 1'b0;
    logic [5:0]       stall;
    logic             mc_busy;
    logic             mc_finish;
    logic             mc_timeout;
`ifdef STALL_STATS_EN
    logic [31:0]      stall_cycles;
`endif

    pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .mc_start         (mc_start),
        .mc_cycles        (mc_cycles),
        .mc_done          (mc_done),
        .mc_flush         (mc_flush),
        .stall            (stall),
        .mc_busy          (mc_busy),
        .mc_finish        (mc_finish),
        .mc_timeout       (mc_timeout)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] stall;
        logic       busy;
        logic       fin;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, then compare on the falling edge.
    task automatic step(input logic id, input logic ex, input logic st, input logic [6:0] n,
                        input logic dn, input logic fl, input logic [5:0] es,
                        input logic eb, input logic ef, input logic et);
        exp_t e;
        exp_t p;
        stallreq_from_id = id;
        stallreq_from_ex = ex;
        mc_start         = st;
        mc_cycles        = n;
        mc_done          = dn;
        mc_flush         = fl;
        e.stall = es; e.busy = eb; e.fin = ef; e.to = et;
        exp_q.push_back(e);
        @(negedge clk);
        p = exp_q.pop_front();
        check("stall",      {26'd0, stall},      {26'd0, p.stall});
        check("mc_busy",    {31'd0, mc_busy},    {31'd0, p.busy});
        check("mc_finish",  {31'd0, mc_finish},  {31'd0, p.fin});
        check("mc_timeout", {31'd0, mc_timeout}, {31'd0, p.to});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Settle state under reset before the first compared cycle.
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("txn: reset with all requests high");
        step(1, 1, 1, 7'd3, 1, 0, 6'b000000, 0, 0, 0);
        rst = 1'b0;
        $display("txn: hazard request decode");
        step(1, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

        $display("txn: counted op, 3 cycles, start held in FIN");
        step(0, 0, 1, 7'd3, 0, 0, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0);
        step(0, 0, 1, 7'd3, 0, 0, 6'b000000, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

        $display("txn: done-mode op, done on RUN cycle 5");
        step(0, 0, 1, 7'd0, 0, 0, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 6'b001111, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

        $display("txn: done-mode op, watchdog");
        step(0, 0, 1, 7'd0, 0, 0, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

        $display("txn: flush with simultaneous done");
        step(0, 0, 1, 7'd0, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 6'b001111, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

        $display("txn: flush on last counted cycle");
        step(0, 0, 1, 7'd2, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 6'b001111, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

        $display("txn: ID request during FIN");
        step(0, 0, 1, 7'd1, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 6'b000111, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

        $display("txn: back-to-back ops");
        step(0, 0, 1, 7'd1, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        step(0, 0, 1, 7'd1, 0, 0, 6'b000000, 0, 1, 1);
        step(0, 0, 1, 7'd1, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

        $display("txn: reset mid-op");
        step(0, 0, 1, 7'd10, 0, 0, 6'b000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 1);
        rst = 1'b1;
        step(1, 1, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);

`ifdef STALL_STATS_EN
        $display("txn: stall statistics");
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 1, 7'd3, 0, 0, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
        check("stall_cycles", stall_cycles, 32'd5);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
